// File: rtl/pe_array_64_if.sv
// Bus bundle for pe_array_64: stripe/reference inputs from the sequence-fetch
// controller and per-stripe results toward the traceback/result logic.
interface pe_array_64_if;
    logic         i_start;
    logic [127:0] i_B;
    logic [1:0]   i_A;
    logic         o_stripe_end;
    logic [9:0]   o_start_position;
    logic [9:0]   o_end_position;
    logic [13:0]  o_max_score_stripe;
    logic [1:0]   o_trace_dir;

    modport master (
        output i_start, i_B, i_A,
        input  o_stripe_end, o_start_position, o_end_position, o_max_score_stripe, o_trace_dir
    );

    modport slave (
        input  i_start, i_B, i_A,
        output o_stripe_end, o_start_position, o_end_position, o_max_score_stripe, o_trace_dir
    );
endinterface

// File: rtl/pe_array_64.sv
// 64-PE systolic Smith-Waterman stripe scorer with ping-pong column-63 boundary buffers.
// Optional macro PE_ARRAY_TRACE_EN enables the PE63 traceback direction output.
module pe_array_64 (
    input  logic         i_clk,
    input  logic         i_rst,
    pe_array_64_if.slave bus
);
    localparam int unsigned N_PE  = 64;
    localparam int unsigned SW    = 14;
    localparam int unsigned RW    = 10;
    localparam int unsigned CW    = 11;
    localparam int unsigned DEPTH = 1024;

    typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

    state_t state_q, state_d;
    logic [5:0] drain_q;
    logic accept, clear_pe, in_idle, in_done, load_out;

    // One cell: H = max(0, diag + s, up - 1, left - 1), all unsigned
    function automatic logic [SW-1:0] pe_score(input logic [1:0] a, input logic [1:0] b,
                                               input logic [SW-1:0] diag, input logic [SW-1:0] up,
                                               input logic [SW-1:0] left);
        logic [SW-1:0] ds, um, lm, h;
        if (a == b) ds = diag + SW'(2);
        else        ds = (diag != '0) ? diag - SW'(1) : '0;
        um = (up   != '0) ? up   - SW'(1) : '0;
        lm = (left != '0) ? left - SW'(1) : '0;
        h = ds;
        if (um > h) h = um;
        if (lm > h) h = lm;
        return h;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_start)       state_d = RUN;
            RUN:     if (!bus.i_start)      state_d = EVAL;
            EVAL:    if (drain_q == 6'd62)  state_d = DONE;
            DONE:                           state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        clear_pe = 1'b0;
        in_idle  = 1'b0;
        in_done  = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE: begin
                in_idle  = 1'b1;
                clear_pe = 1'b1;
                accept   = bus.i_start;
            end
            RUN:  accept   = bus.i_start;
            EVAL: load_out = (drain_q == 6'd62);
            DONE: begin
                in_done  = 1'b1;
                clear_pe = 1'b1;
            end
            default: ;
        endcase
    end

    logic [127:0]    b_q;
    logic [RW-1:0]   row_q;
    logic [SW-1:0]   h_q  [N_PE];
    logic [SW-1:0]   hd_q [N_PE-1];
    logic [1:0]      a_q  [N_PE-1];
    logic [RW-1:0]   r_q  [N_PE-1];
    logic [N_PE-2:0] v_q;
    logic [SW-1:0]   left0_prev_q;

    logic [SW-1:0] mem0 [DEPTH];
    logic [SW-1:0] mem1 [DEPTH];
    logic          sel_q;
    logic [CW-1:0] cnt0_q, cnt1_q;
    logic          found_q;
    logic [RW-1:0] start_q;
    logic [SW-1:0] max_q;
    logic [RW-1:0] max_row_q;

    logic          stripe_end_q;
    logic [RW-1:0] start_out_q, end_out_q;
    logic [SW-1:0] max_out_q;

    logic [RW-1:0] row0;
    logic [1:0]    b0;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic [SW-1:0] rd_val, left0;
    logic          wr_en;

    logic [N_PE-1:0] pe_v;
    logic [RW-1:0]   pe_row [N_PE];
    logic [SW-1:0]   pe_h   [N_PE];
    logic [1:0]      pe_a   [N_PE];
    logic [SW-1:0]   best_s;
    logic [RW-1:0]   best_r;

    // PE0 boundary read: entries past the stored count read as zero
    always_comb begin
        row0   = in_idle ? '0 : row_q;
        b0     = in_idle ? bus.i_B[1:0] : b_q[1:0];
        rd_cnt = sel_q ? cnt1_q : cnt0_q;
        wr_cnt = sel_q ? cnt0_q : cnt1_q;
        rd_val = sel_q ? mem1[row0] : mem0[row0];
        left0  = ({1'b0, row0} < rd_cnt) ? rd_val : '0;
    end

    always_comb begin
        pe_v = '0;
        for (int unsigned k = 0; k < N_PE; k++) begin
            pe_row[k] = '0;
            pe_h[k]   = '0;
            pe_a[k]   = '0;
        end
        pe_v[0]   = accept;
        pe_row[0] = row0;
        pe_a[0]   = bus.i_A;
        pe_h[0]   = pe_score(bus.i_A, b0, left0_prev_q, h_q[0], left0);
        for (int unsigned k = 1; k < N_PE; k++) begin
            pe_v[k]   = v_q[k-1];
            pe_row[k] = r_q[k-1];
            pe_a[k]   = a_q[k-1];
            pe_h[k]   = pe_score(a_q[k-1], b_q[2*k +: 2], hd_q[k-1], h_q[k], h_q[k-1]);
        end
    end

    // Row-major maximum: higher score wins, equal score keeps the earlier row
    always_comb begin
        best_s = max_q;
        best_r = max_row_q;
        for (int unsigned k = 0; k < N_PE; k++) begin
            if (pe_v[k] && ((pe_h[k] > best_s) ||
                            ((pe_h[k] == best_s) && (pe_row[k] < best_r)))) begin
                best_s = pe_h[k];
                best_r = pe_row[k];
            end
        end
    end

    assign wr_en = pe_v[N_PE-1] && (found_q || (pe_h[N_PE-1] != '0)) && !wr_cnt[CW-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            b_q          <= '0;
            row_q        <= '0;
            drain_q      <= '0;
            v_q          <= '0;
            left0_prev_q <= '0;
            for (int unsigned k = 0; k < N_PE; k++) h_q[k] <= '0;
            for (int unsigned k = 0; k < N_PE-1; k++) begin
                hd_q[k] <= '0;
                a_q[k]  <= '0;
                r_q[k]  <= '0;
            end
            sel_q        <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
            found_q      <= 1'b0;
            start_q      <= '0;
            max_q        <= '0;
            max_row_q    <= '0;
            stripe_end_q <= 1'b0;
            start_out_q  <= '0;
            end_out_q    <= '0;
            max_out_q    <= '0;
        end else begin
            if (in_idle) b_q <= bus.i_B;
            if (accept)  row_q <= (row0 == RW'(DEPTH-1)) ? row0 : row0 + RW'(1);
            drain_q <= (state_q == EVAL) ? drain_q + 6'd1 : 6'd0;

            if (accept) begin
                h_q[0]       <= pe_h[0];
                hd_q[0]      <= h_q[0];
                a_q[0]       <= bus.i_A;
                r_q[0]       <= row0;
                left0_prev_q <= left0;
            end else if (clear_pe) begin
                h_q[0]       <= '0;
                hd_q[0]      <= '0;
                left0_prev_q <= '0;
            end
            v_q[0] <= accept;

            for (int unsigned k = 1; k < N_PE-1; k++) begin
                if (clear_pe) begin
                    h_q[k]  <= '0;
                    hd_q[k] <= '0;
                    v_q[k]  <= 1'b0;
                end else begin
                    v_q[k] <= pe_v[k];
                    if (pe_v[k]) begin
                        h_q[k]  <= pe_h[k];
                        hd_q[k] <= h_q[k];
                        a_q[k]  <= pe_a[k];
                        r_q[k]  <= pe_row[k];
                    end
                end
            end
            if (clear_pe)              h_q[N_PE-1] <= '0;
            else if (pe_v[N_PE-1])     h_q[N_PE-1] <= pe_h[N_PE-1];

            if (in_done) begin
                max_q     <= '0;
                max_row_q <= '0;
            end else begin
                max_q     <= best_s;
                max_row_q <= best_r;
            end

            // Column-63 capture starts at the first positive row of the stripe
            if (in_idle) begin
                found_q <= 1'b0;
                start_q <= '0;
                if (sel_q) cnt0_q <= '0;
                else       cnt1_q <= '0;
            end else if (wr_en) begin
                if (sel_q) cnt0_q <= cnt0_q + CW'(1);
                else       cnt1_q <= cnt1_q + CW'(1);
                if (!found_q) begin
                    found_q <= 1'b1;
                    start_q <= pe_row[N_PE-1];
                end
            end
            if (in_done) sel_q <= ~sel_q;

            stripe_end_q <= load_out;
            if (load_out) begin
                max_out_q   <= max_q;
                end_out_q   <= max_row_q;
                start_out_q <= start_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en && !i_rst) begin
            if (sel_q) mem0[wr_cnt[RW-1:0]] <= pe_h[N_PE-1];
            else       mem1[wr_cnt[RW-1:0]] <= pe_h[N_PE-1];
        end
    end

    assign bus.o_stripe_end       = stripe_end_q;
    assign bus.o_start_position   = start_out_q;
    assign bus.o_end_position     = end_out_q;
    assign bus.o_max_score_stripe = max_out_q;

`ifdef PE_ARRAY_TRACE_EN
    // Direction priority diag > up > left; zero score reports 0
    function automatic logic [1:0] pe_dir(input logic [1:0] a, input logic [1:0] b,
                                          input logic [SW-1:0] diag, input logic [SW-1:0] up,
                                          input logic [SW-1:0] left, input logic [SW-1:0] h);
        logic [SW-1:0] ds, um, lm;
        if (a == b) ds = diag + SW'(2);
        else        ds = (diag != '0) ? diag - SW'(1) : '0;
        um = (up   != '0) ? up   - SW'(1) : '0;
        lm = (left != '0) ? left - SW'(1) : '0;
        if (h == '0)       return 2'd0;
        else if (h == ds)  return 2'd1;
        else if (h == um)  return 2'd2;
        else if (h == lm)  return 2'd3;
        else               return 2'd3;
    endfunction

    logic [1:0] trace_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) trace_q <= 2'd0;
        else       trace_q <= pe_v[N_PE-1]
                              ? pe_dir(pe_a[N_PE-1], b_q[127:126], hd_q[N_PE-2], h_q[N_PE-1],
                                       h_q[N_PE-2], pe_h[N_PE-1])
                              : 2'd0;
    end
    assign bus.o_trace_dir = trace_q;
`else
    assign bus.o_trace_dir = 2'd0;
`endif
endmodule

// File: tb/tb_pe_array_64.sv
// Directed bench for pe_array_64: reset, identical/mismatch stripes, pruning,
// mid-stripe reset and two-stripe boundary continuity.
module tb_pe_array_64;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_array_64_if bus();
    pe_array_64 dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] ref_a [2048];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_query_const(input logic [1:0] c);
        for (int k = 0; k < 64; k++) bus.i_B[2*k +: 2] = c;
    endtask

    // Stream len bases from ref_a[off], then check latency, results and pulse width
    task automatic stripe(input string tag, input int off, input int len,
                          input int exp_max, input int exp_end, input int exp_start);
        int lat;
        for (int i = 0; i < len; i++) begin
            bus.i_start = 1'b1;
            bus.i_A     = ref_a[off+i];
            tick();
        end
        bus.i_start = 1'b0;
        bus.i_A     = 2'd0;
        tick();
        lat = 0;
        while (bus.o_stripe_end !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 63);
        check({tag, "_max"}, bus.o_max_score_stripe, exp_max);
        check({tag, "_end_pos"}, bus.o_end_position, exp_end);
        if (exp_start >= 0) check({tag, "_start_pos"}, bus.o_start_position, exp_start);
        tick();
        check({tag, "_pulse_width"}, bus.o_stripe_end, 0);
    endtask

    initial begin
        int pulses;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_A     = 2'd0;
        bus.i_B     = '0;

        // Reset held two cycles
        tick();
        check("rst_pulse_c1", bus.o_stripe_end, 0);
        tick();
        check("rst_pulse_c2", bus.o_stripe_end, 0);
        rst = 1'b0;
        tick();
        check("rst_max", bus.o_max_score_stripe, 0);
        check("rst_start", bus.o_start_position, 0);
        check("rst_end", bus.o_end_position, 0);
        check("rst_trace", bus.o_trace_dir, 0);
        check("rst_pulse", bus.o_stripe_end, 0);

        // Identical query/reference, 64 rows
        for (int k = 0; k < 64; k++) begin
            bus.i_B[2*k +: 2] = 2'(k % 4);
            ref_a[k]          = 2'(k % 4);
        end
        stripe("ident", 0, 64, 128, 63, -1);

        // Reset in the middle of a stripe
        set_query_const(2'd2);
        for (int i = 0; i < 30; i++) begin
            bus.i_start = 1'b1;
            bus.i_A     = 2'd2;
            tick();
        end
        rst         = 1'b1;
        bus.i_start = 1'b0;
        tick();
        rst = 1'b0;
        check("midrst_max", bus.o_max_score_stripe, 0);
        check("midrst_end", bus.o_end_position, 0);
        check("midrst_start", bus.o_start_position, 0);
        check("midrst_pulse", bus.o_stripe_end, 0);
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.o_stripe_end === 1'b1) pulses++;
        end
        check("midrst_no_done", pulses, 0);

        // All mismatches, full 1024 rows, must see a zero boundary after reset
        set_query_const(2'd0);
        for (int i = 0; i < 1024; i++) ref_a[i] = 2'd1;
        stripe("mism", 0, 1024, 0, 0, 0);

        // Leading zero rows pruned from the next-stripe offset
        for (int i = 0; i < 20; i++) ref_a[i] = (i < 10) ? 2'd1 : 2'd0;
        stripe("prune", 0, 20, 20, 19, 10);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Two-stripe continuity through the column-63 boundary buffer
        set_query_const(2'd2);
        for (int i = 0; i < 138; i++) ref_a[i] = (i < 10) ? 2'd1 : 2'd2;
        stripe("cont1", 0, 138, 128, 73, 10);
        stripe("cont2", 10, 128, 256, 127, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
